// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and pipeline geometry helpers.
package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple slice; also exposes the carry into its MSB
// so the last slice can derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_s[i]),
      .sum  (sum[i]),
      .cout (carry_s[i+1])
    );
  end

  assign cout  = carry_s[CHUNK];
  assign c_msb = carry_s[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Team's 1-bit full adder, the building block of every carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit carry slice per register
// stage, a single global stall, and registered sum/carry/overflow/zero.
module pipelined_adder_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("pipelined_adder_sub: WIDTH must be a multiple of CHUNK");
  end

  logic             advance_s;
  logic             st_valid_s [STAGES];
  logic             st_sub_s   [STAGES];
  logic             st_carry_s [STAGES];
  logic             st_ovf_s   [STAGES];
  logic             st_zero_s  [STAGES];
  logic [WIDTH-1:0] st_a_s     [STAGES];
  logic [WIDTH-1:0] st_b_s     [STAGES];
  logic [WIDTH-1:0] st_sum_s   [STAGES];

  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             valid_in_s;
    logic             sub_in_s;
    logic             cin_s;
    logic [WIDTH-1:0] a_in_s;
    logic [WIDTH-1:0] b_in_s;
    logic [WIDTH-1:0] sum_in_s;
    logic [WIDTH-1:0] sum_nxt_s;
    logic [CHUNK-1:0] chunk_sum_s;
    logic             cout_s;
    logic             c_msb_s;

    logic             valid_r;
    logic             sub_r;
    logic             carry_r;
    logic             ovf_r;
    logic             zero_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;

    // Stage 0 takes the ports; later stages take the previous stage's registers.
    if (k == 0) begin : g_first
      assign valid_in_s = in_valid;
      assign sub_in_s   = Sub;
      assign a_in_s     = A;
      assign b_in_s     = B;
      assign sum_in_s   = {WIDTH{1'b0}};
      assign cin_s      = (Sub == ALU_OP_SUB) ? 1'b1 : Cin;
    end else begin : g_next
      assign valid_in_s = st_valid_s[k-1];
      assign sub_in_s   = st_sub_s[k-1];
      assign a_in_s     = st_a_s[k-1];
      assign b_in_s     = st_b_s[k-1];
      assign sum_in_s   = st_sum_s[k-1];
      assign cin_s      = st_carry_s[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_in_s[k*CHUNK +: CHUNK]),
      .b     (b_in_s[k*CHUNK +: CHUNK] ^ {CHUNK{sub_in_s}}),
      .cin   (cin_s),
      .sum   (chunk_sum_s),
      .cout  (cout_s),
      .c_msb (c_msb_s)
    );

    // Merge this slice's result into the partial sum carried by the transaction.
    always_comb begin
      sum_nxt_s = sum_in_s;
      sum_nxt_s[k*CHUNK +: CHUNK] = chunk_sum_s;
    end

    // Stage register: bubbles only clear valid, so data holds and X inputs are never captured.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        sub_r   <= 1'b0;
        carry_r <= 1'b0;
        ovf_r   <= 1'b0;
        zero_r  <= 1'b0;
        a_r     <= {WIDTH{1'b0}};
        b_r     <= {WIDTH{1'b0}};
        sum_r   <= {WIDTH{1'b0}};
      end else if (advance_s) begin
        valid_r <= valid_in_s;
        if (valid_in_s) begin
          sub_r   <= sub_in_s;
          carry_r <= cout_s;
          ovf_r   <= c_msb_s ^ cout_s;
          zero_r  <= (sum_nxt_s == {WIDTH{1'b0}});
          a_r     <= a_in_s;
          b_r     <= b_in_s;
          sum_r   <= sum_nxt_s;
        end
      end
    end

    assign st_valid_s[k] = valid_r;
    assign st_sub_s[k]   = sub_r;
    assign st_carry_s[k] = carry_r;
    assign st_ovf_s[k]   = ovf_r;
    assign st_zero_s[k]  = zero_r;
    assign st_a_s[k]     = a_r;
    assign st_b_s[k]     = b_r;
    assign st_sum_s[k]   = sum_r;
  end

  assign out_valid = st_valid_s[STAGES-1];
  assign Sum       = st_sum_s[STAGES-1];
  assign Carry     = st_carry_s[STAGES-1];
  assign Overflow  = st_ovf_s[STAGES-1];
  assign Zero      = st_zero_s[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Directed bench for pipelined_adder_sub at WIDTH=8, CHUNK=2 (four stages).
module tb_pipelined_adder_sub;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry;
  logic       overflow;
  logic       zero;

  int tests_run;
  int tests_failed;

  pipelined_adder_sub #(.WIDTH(8), .CHUNK(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .Sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum),
    .Carry     (carry),
    .Overflow  (overflow),
    .Zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, sum, carry, overflow, zero} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_hold: got v=%b sum=%h c=%b o=%b z=%b, expected all 0", out_valid, sum, carry, overflow, zero);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
    end
    // Mid-stream: hold a wrap result at the output, then reset under it.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({out_valid, sum, carry, overflow, zero} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_prefill: got v=%b sum=%h c=%b o=%b z=%b, expected v=1 sum=00 c=1 o=0 z=1", out_valid, sum, carry, overflow, zero);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, sum, carry, overflow, zero} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_async: got v=%b sum=%h c=%b o=%b z=%b, expected all 0", out_valid, sum, carry, overflow, zero);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_after: got ready=%b v=%b, expected ready=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single(input string name, input logic [7:0] va, input logic [7:0] vb,
                             input logic vcin, input logic vsub, input logic [7:0] esum,
                             input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_accept: got in_ready=%b, expected 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; a = 8'hxx; b = 8'hxx; cin = 1'bx; sub = 1'bx;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_latency: got out_valid=%b at cycle %0d, expected 0", name, out_valid, i + 1);
      end
      @(negedge clk);
    end
    tests_run++;
    if ({out_valid, sum, carry, overflow, zero} !== {1'b1, esum, ec, eo, ez}) begin
      tests_failed++;
      $display("FAIL %s: got v=%b sum=%h c=%b o=%b z=%b, expected v=1 sum=%h c=%b o=%b z=%b",
               name, out_valid, sum, carry, overflow, zero, esum, ec, eo, ez);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_sum [6] = '{8'h10, 8'h12, 8'h14, 8'h16, 8'h18, 8'h1A};
    int tx = 0;
    int rx = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stall_started = 1'b0;
    bit held = 1'b0;
    logic [7:0] held_sum = 8'h00;
    @(negedge clk);
    while (rx < 6 && cyc < 40) begin
      if (!stall_started && out_valid) begin
        stall_started = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid = (tx < 6);
      if (tx < 6) begin
        a = 8'(8'h10 + tx); b = 8'(tx); cin = 1'b0; sub = 1'b0;
      end else begin
        a = 8'hxx; b = 8'hxx; cin = 1'bx; sub = 1'bx;
      end
      #1;
      if (out_valid && !out_ready) begin
        tests_run++;
        if (in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_stall_ready: got in_ready=%b, expected 0", in_ready);
        end
        if (held) begin
          tests_run++;
          if (sum !== held_sum) begin
            tests_failed++;
            $display("FAIL b2b_stall_stable: got sum=%h, expected %h", sum, held_sum);
          end
        end else begin
          held = 1'b1;
          held_sum = sum;
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if ({sum, carry, overflow, zero} !== {exp_sum[rx], 3'b000}) begin
          tests_failed++;
          $display("FAIL b2b_result%0d: got sum=%h c=%b o=%b z=%b, expected sum=%h c=0 o=0 z=0",
                   rx, sum, carry, overflow, zero, exp_sum[rx]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
      if (stall_left > 0) stall_left--;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++;
    if (rx != 6 || tx != 6 || !stall_started) begin
      tests_failed++;
      $display("FAIL b2b_count: got sent=%0d received=%0d stalled=%0d, expected 6 6 1", tx, rx, stall_started);
    end
  endtask

  task automatic test_bubbles();
    logic       vin   [14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] in_a  [4] = '{8'h20, 8'h40, 8'hF0, 8'h00};
    logic [7:0] in_b  [4] = '{8'h0F, 8'h0F, 8'h20, 8'h01};
    logic       in_s  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] e_sum [4] = '{8'h2F, 8'h31, 8'h10, 8'hFF};
    logic       e_c   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int idx = 0;
    int ox = 0;
    logic exp_v;
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_valid = vin[c];
      if (vin[c]) begin
        a = in_a[idx]; b = in_b[idx]; sub = in_s[idx]; cin = 1'b0;
        idx++;
      end else begin
        a = 8'hxx; b = 8'hxx; sub = 1'bx; cin = 1'bx;
      end
      #1;
      exp_v = (c >= 4) ? vin[c-4] : 1'b0;
      tests_run++;
      if (out_valid !== exp_v) begin
        tests_failed++;
        $display("FAIL bubble_valid%0d: got out_valid=%b, expected %b", c, out_valid, exp_v);
      end
      if (out_valid === 1'b1 && ox < 4) begin
        tests_run++;
        if ({sum, carry, overflow} !== {e_sum[ox], e_c[ox], 1'b0}) begin
          tests_failed++;
          $display("FAIL bubble_result%0d: got sum=%h c=%b o=%b, expected sum=%h c=%b o=0",
                   ox, sum, carry, overflow, e_sum[ox], e_c[ox]);
        end
        ox++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single("add_wrap",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    test_single("add_ovf_cin", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    test_single("add_cin",     8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0);
    test_single("sub_ovf",     8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    test_single("sub_borrow",  8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    test_single("sub_zero",    8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    test_back_to_back();
    test_bubbles();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
